pingpong_bank_reader: RTL and testbench

//  Downstream consumer of the ping-pong BRAM pair. It waits for a filled bank, reads DEPTH words

---
 rtl/pingpong_bank_reader.sv | 154 +++++++++++++++
 tb/tb_pingpong_bank_reader.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_bank_reader.sv
// pingpong_bank_reader: drains a filled ping-pong BRAM bank through a
// 1-cycle-latency read port into a valid/ready stream via a 2-entry skid FIFO.
// Ports: clk, rst (async, active-high)
//        bank_valid/bank_sel in, bank_done out : bank handoff with the writer
//        rd_bank/rd_en/rd_addr out, rd_data in  : BRAM read port
//        m_valid/m_data/m_last out, m_ready in  : output stream
module pingpong_bank_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bank_valid,
  input  logic              bank_sel,
  output logic              bank_done,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]     LASTW_C = CW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LASTA_C = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_REL
  } state_t;

  state_t state_q, state_d;

  logic              rd_bank_q;
  logic [CW-1:0]     issue_cnt_q;
  logic [CW-1:0]     out_cnt_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q;

  logic [DATA_W-1:0] mem_q  [2];
  logic              last_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;

  logic       start;
  logic       push;
  logic       pop;
  logic [2:0] credit;

  assign start   = (state_q == S_IDLE) && bank_valid;
  assign push    = inflight_q;
  assign m_valid = (count_q != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem_q[rd_ptr_q];
  assign m_last  = m_valid && last_q[rd_ptr_q];
  assign rd_bank = rd_bank_q;
  assign rd_addr = addr_q;

  // Words already owed to the FIFO: stored plus the read still in the BRAM.
  assign credit  = {1'b0, count_q} + {2'b00, inflight_q};

  // rd_addr wraps at DEPTH so it never points past the bank.
  assign addr_d  = (addr_q == LASTA_C) ? '0 : addr_q + ADDR_W'(1);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bank_valid) state_d = S_READ;
      S_READ:  if (rd_en && issue_cnt_q == LASTW_C) state_d = S_DRAIN;
      S_DRAIN: if (pop && m_last) state_d = S_REL;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; a read is issued only if its word still has a FIFO
  // slot once this cycle's pop has been taken.
  always_comb begin
    rd_en     = 1'b0;
    bank_done = 1'b0;
    unique case (state_q)
      S_READ:  rd_en = (issue_cnt_q < DEPTH_C) &&
                       (credit < (3'd2 + {2'b00, pop}));
      S_REL:   bank_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: counters, in-flight tracking and skid FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q   <= 1'b0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      inflight_q <= rd_en;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q]  <= rd_data;
        last_q[wr_ptr_q] <= (out_cnt_q == LASTW_C);
        wr_ptr_q         <= ~wr_ptr_q;
        out_cnt_q        <= out_cnt_q + CW'(1);
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (start) begin
        rd_bank_q   <= bank_sel;
        issue_cnt_q <= '0;
        out_cnt_q   <= '0;
        addr_q      <= '0;
      end else if (rd_en) begin
        issue_cnt_q <= issue_cnt_q + CW'(1);
        addr_q      <= addr_d;
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !pop && count_q == 2'd2)
  );

endmodule

// File: tb/tb_pingpong_bank_reader.sv
// tb_pingpong_bank_reader: random-data scoreboard bench for the
// ping-pong bank reader, including DEPTH=2 and DEPTH=64 instances.
module tb_pingpong_bank_reader;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int SD0 = 2;
  localparam int SD1 = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- main DUT (DEPTH = 8) ----------------
  logic          bank_valid = 1'b0;
  logic          bank_sel   = 1'b0;
  logic          m_ready    = 1'b0;
  logic          bank_done, rd_bank, rd_en, m_valid, m_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_data;

  logic [DW-1:0] bram1 [64];
  logic [DW-1:0] bram2 [64];

  pingpong_bank_reader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst),
    .bank_valid(bank_valid), .bank_sel(bank_sel), .bank_done(bank_done),
    .rd_bank(rd_bank), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always @(posedge clk)
    if (rd_en) rd_data <= rd_bank ? bram2[rd_addr] : bram1[rd_addr];

  // Recorder: observes the stream and read port between edges.
  logic [DW-1:0] pq [$];
  bit            lq [$];
  int            pcyc [$];
  int            icyc [$];
  int            iaddr [$];
  bit            ibank [$];
  int            dcyc [$];
  int            first_mv, issue_viol, stall_viol, outst;
  bit            prev_stall;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin : mon
    bit pop;
    if (rst) begin
      pq.delete(); lq.delete(); pcyc.delete(); icyc.delete();
      iaddr.delete(); ibank.delete(); dcyc.delete();
      first_mv = -1; issue_viol = 0; stall_viol = 0; outst = 0;
      prev_stall = 1'b0; prev_data = '0;
    end else begin
      pop = m_valid && m_ready;
      if (rd_en && (outst - int'(pop) >= 2)) issue_viol++;
      if (prev_stall && (!m_valid || m_data !== prev_data)) stall_viol++;
      if (rd_en) begin
        icyc.push_back(cyc);
        iaddr.push_back(int'(rd_addr));
        ibank.push_back(rd_bank);
      end
      if (pop) begin
        pq.push_back(m_data);
        lq.push_back(m_last);
        pcyc.push_back(cyc);
      end
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (bank_done) dcyc.push_back(cyc);
      outst = outst + int'(rd_en) - int'(pop);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // ---------------- sweep DUTs (DEPTH = 2, 64) ----------------
  logic          s_bv [2] = '{1'b0, 1'b0};
  logic          s_bs [2] = '{1'b0, 1'b0};
  logic          s_mr [2] = '{1'b0, 1'b0};
  logic          s_done [2];
  logic          s_rb [2];
  logic          s_re [2];
  logic [AW-1:0] s_ra [2];
  logic [DW-1:0] s_rd [2];
  logic          s_mv [2];
  logic [DW-1:0] s_md [2];
  logic          s_ml [2];
  logic [DW-1:0] sbram [2][2][64];
  int            s_words [2];
  int            s_derr [2];
  int            s_lerr [2];
  int            s_dn [2];

  for (genvar g = 0; g < 2; g++) begin : sw
    pingpong_bank_reader #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(g == 0 ? SD0 : SD1)
    ) u_sw (
      .clk(clk), .rst(rst),
      .bank_valid(s_bv[g]), .bank_sel(s_bs[g]), .bank_done(s_done[g]),
      .rd_bank(s_rb[g]), .rd_en(s_re[g]), .rd_addr(s_ra[g]), .rd_data(s_rd[g]),
      .m_valid(s_mv[g]), .m_data(s_md[g]), .m_last(s_ml[g]), .m_ready(s_mr[g])
    );
  end

  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (s_re[g]) s_rd[g] <= sbram[g][s_rb[g]][s_ra[g]];

  // Reference: bank b (alternating 0,1) delivers sbram[g][b][0..d-1] in order.
  always @(negedge clk) begin : smon
    int d, k;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        s_words[g] = 0; s_derr[g] = 0; s_lerr[g] = 0; s_dn[g] = 0;
      end else begin
        d = (g == 0) ? SD0 : SD1;
        if (s_mv[g] && s_mr[g]) begin
          k = s_words[g] % d;
          if (s_md[g] !== sbram[g][(s_words[g] / d) % 2][k]) s_derr[g]++;
          if (s_ml[g] !== (k == d - 1)) s_lerr[g]++;
          s_words[g]++;
        end
        if (s_done[g]) s_dn[g]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; bank_valid = 1'b0; m_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Runs the main DUT until ndone bank_done pulses; on each pulse flips
  // bank_sel (more banks wanted) or drops bank_valid (last bank).
  task automatic drv(input int mode, input int ndone, input int budget,
                     output bit tmo);
    int h;
    h = 0;
    tmo = 1'b1;
    for (int c = 0; c < budget; c++) begin
      step();
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (c % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (dcyc.size() > h) begin
        h++;
        if (h < ndone) bank_sel = ~bank_sel;
        else           bank_valid = 1'b0;
      end
      if (h >= ndone) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step();
    n_chk++; if (bank_done !== 1'b0) begin n_fail++; $display("FAIL rst_bank_done: got %b want 0", bank_done); end
    n_chk++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL rst_rd_bank: got %b want 0", rd_bank); end
    n_chk++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
    n_chk++; if (rd_addr !== '0) begin n_fail++; $display("FAIL rst_rd_addr: got %0h want 0", rd_addr); end
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_chk++; if (m_data !== '0) begin n_fail++; $display("FAIL rst_m_data: got %0h want 0", m_data); end
    n_chk++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    bit tmo;
    do_reset();
    for (int i = 0; i < 64; i++) bram1[i] = 8'h10 + 8'(i);
    bank_sel = 1'b0; bank_valid = 1'b1; m_ready = 1'b1;
    drv(0, 1, 100, tmo);
    repeat (3) step();
    n_chk++; if (tmo) begin n_fail++; $display("FAIL t1_timeout: got 1 want 0"); end
    n_chk++; if (pq.size() != 8) begin n_fail++; $display("FAIL t1_count: got %0d want 8", pq.size()); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (pq[i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL t1_data[%0d]: got %0h want %0h", i, pq[i], 8'h10 + 8'(i)); end
      n_chk++; if (lq[i] !== (i == 7)) begin n_fail++; $display("FAIL t1_last[%0d]: got %b want %b", i, lq[i], i == 7); end
    end
    n_chk++; if (first_mv - icyc[0] != 2) begin n_fail++; $display("FAIL t1_latency: got %0d want 2", first_mv - icyc[0]); end
    n_chk++; if (pcyc[7] - pcyc[0] != 7) begin n_fail++; $display("FAIL t1_b2b: got %0d want 7", pcyc[7] - pcyc[0]); end
    n_chk++; if (dcyc.size() != 1) begin n_fail++; $display("FAIL t1_done_cnt: got %0d want 1", dcyc.size()); end
    n_chk++; if (dcyc[0] != pcyc[7] + 1) begin n_fail++; $display("FAIL t1_done_cyc: got %0d want %0d", dcyc[0], pcyc[7] + 1); end
  endtask

  task automatic test_backpressure();
    bit tmo;
    do_reset();
    for (int i = 0; i < 64; i++) bram2[i] = 8'($urandom);
    bank_sel = 1'b1; bank_valid = 1'b1; m_ready = 1'b1;
    drv(1, 1, 200, tmo);
    repeat (3) step();
    n_chk++; if (tmo) begin n_fail++; $display("FAIL t2_timeout: got 1 want 0"); end
    n_chk++; if (pq.size() != 8) begin n_fail++; $display("FAIL t2_count: got %0d want 8", pq.size()); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (pq[i] !== bram2[i]) begin n_fail++; $display("FAIL t2_data[%0d]: got %0h want %0h", i, pq[i], bram2[i]); end
      n_chk++; if (iaddr[i] != i) begin n_fail++; $display("FAIL t2_addr[%0d]: got %0d want %0d", i, iaddr[i], i); end
    end
    n_chk++; if (stall_viol != 0) begin n_fail++; $display("FAIL t2_stable: got %0d want 0", stall_viol); end
    n_chk++; if (issue_viol != 0) begin n_fail++; $display("FAIL t2_credit: got %0d want 0", issue_viol); end
    n_chk++; if (dcyc.size() != 1) begin n_fail++; $display("FAIL t2_done_cnt: got %0d want 1", dcyc.size()); end
  endtask

  task automatic test_stall();
    bit tmo;
    do_reset();
    for (int i = 0; i < 64; i++) bram1[i] = 8'($urandom);
    bank_sel = 1'b0; bank_valid = 1'b1; m_ready = 1'b0;
    repeat (20) step();
    @(negedge clk);
    n_chk++; if (icyc.size() != 2) begin n_fail++; $display("FAIL t3_issues: got %0d want 2", icyc.size()); end
    n_chk++; if (iaddr[0] != 0 || iaddr[1] != 1) begin n_fail++; $display("FAIL t3_addrs: got %0d,%0d want 0,1", iaddr[0], iaddr[1]); end
    n_chk++; if (outst != 2) begin n_fail++; $display("FAIL t3_fill: got %0d want 2", outst); end
    n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL t3_valid: got %b want 1", m_valid); end
    n_chk++; if (m_data !== bram1[0]) begin n_fail++; $display("FAIL t3_head: got %0h want %0h", m_data, bram1[0]); end
    drv(0, 1, 100, tmo);
    repeat (3) step();
    n_chk++; if (tmo) begin n_fail++; $display("FAIL t3_timeout: got 1 want 0"); end
    n_chk++; if (pq.size() != 8) begin n_fail++; $display("FAIL t3_count: got %0d want 8", pq.size()); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (pq[i] !== bram1[i]) begin n_fail++; $display("FAIL t3_data[%0d]: got %0h want %0h", i, pq[i], bram1[i]); end
    end
    n_chk++; if (pcyc[7] - pcyc[0] != 7) begin n_fail++; $display("FAIL t3_b2b: got %0d want 7", pcyc[7] - pcyc[0]); end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    logic [DW-1:0] exp;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      bram1[i] = 8'($urandom);
      bram2[i] = 8'($urandom);
    end
    bank_sel = 1'b0; bank_valid = 1'b1; m_ready = 1'b1;
    drv(0, 2, 200, tmo);
    repeat (3) step();
    n_chk++; if (tmo) begin n_fail++; $display("FAIL t4_timeout: got 1 want 0"); end
    n_chk++; if (pq.size() != 16) begin n_fail++; $display("FAIL t4_count: got %0d want 16", pq.size()); end
    n_chk++; if (dcyc.size() != 2) begin n_fail++; $display("FAIL t4_done_cnt: got %0d want 2", dcyc.size()); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 8) ? bram1[i] : bram2[i - 8];
      n_chk++; if (pq[i] !== exp) begin n_fail++; $display("FAIL t4_data[%0d]: got %0h want %0h", i, pq[i], exp); end
      n_chk++; if (ibank[i] !== (i >= 8)) begin n_fail++; $display("FAIL t4_bank[%0d]: got %b want %b", i, ibank[i], i >= 8); end
      n_chk++; if (lq[i] !== (i % 8 == 7)) begin n_fail++; $display("FAIL t4_last[%0d]: got %b want %b", i, lq[i], i % 8 == 7); end
    end
    n_chk++; if (icyc[8] != dcyc[0] + 2) begin n_fail++; $display("FAIL t4_restart: got %0d want %0d", icyc[8], dcyc[0] + 2); end
  endtask

  task automatic test_mid_reset();
    bit tmo;
    int np;
    do_reset();
    for (int i = 0; i < 64; i++) bram1[i] = 8'($urandom);
    bank_sel = 1'b0; bank_valid = 1'b1; m_ready = 1'b1;
    np = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      np = pq.size();
      if (np >= 3) break;
    end
    n_chk++; if (np != 3) begin n_fail++; $display("FAIL t5_pops: got %0d want 3", np); end
    step();
    rst = 1'b1; bank_valid = 1'b0;
    #1;
    n_chk++;
    if ({bank_done, rd_bank, rd_en, rd_addr, m_valid, m_data, m_last} !== '0) begin
      n_fail++;
      $display("FAIL t5_outs: got done=%b en=%b addr=%0h v=%b d=%0h l=%b want all 0",
               bank_done, rd_en, rd_addr, m_valid, m_data, m_last);
    end
    step();
    rst = 1'b0;
    repeat (6) step();
    n_chk++; if (dcyc.size() != 0) begin n_fail++; $display("FAIL t5_no_done: got %0d want 0", dcyc.size()); end
    n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL t5_flushed: got %b want 0", m_valid); end
    bank_valid = 1'b1;
    drv(0, 1, 100, tmo);
    repeat (3) step();
    n_chk++; if (tmo) begin n_fail++; $display("FAIL t5_timeout: got 1 want 0"); end
    n_chk++; if (iaddr[0] != 0) begin n_fail++; $display("FAIL t5_addr0: got %0d want 0", iaddr[0]); end
    n_chk++; if (pq.size() != 8) begin n_fail++; $display("FAIL t5_count: got %0d want 8", pq.size()); end
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (pq[i] !== bram1[i]) begin n_fail++; $display("FAIL t5_data[%0d]: got %0h want %0h", i, pq[i], bram1[i]); end
    end
  endtask

  task automatic test_sweep();
    int  h [2];
    int  d;
    bit  tmo;
    do_reset();
    for (int g = 0; g < 2; g++)
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 64; i++) sbram[g][b][i] = 8'($urandom);
    h = '{0, 0};
    s_bs = '{1'b0, 1'b0};
    s_bv = '{1'b1, 1'b1};
    tmo = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int g = 0; g < 2; g++) begin
        s_mr[g] = 1'($urandom_range(0, 1));
        if (s_dn[g] > h[g]) begin
          h[g]++;
          if (h[g] < 2) s_bs[g] = ~s_bs[g];
          else          s_bv[g] = 1'b0;
        end
      end
      if (h[0] >= 2 && h[1] >= 2) begin
        tmo = 1'b0;
        break;
      end
    end
    repeat (4) step();
    n_chk++; if (tmo) begin n_fail++; $display("FAIL t6_timeout: got 1 want 0"); end
    for (int g = 0; g < 2; g++) begin
      d = (g == 0) ? SD0 : SD1;
      n_chk++; if (s_words[g] != 2 * d) begin n_fail++; $display("FAIL t6_words[D=%0d]: got %0d want %0d", d, s_words[g], 2 * d); end
      n_chk++; if (s_derr[g] != 0) begin n_fail++; $display("FAIL t6_data[D=%0d]: got %0d bad want 0", d, s_derr[g]); end
      n_chk++; if (s_lerr[g] != 0) begin n_fail++; $display("FAIL t6_last[D=%0d]: got %0d bad want 0", d, s_lerr[g]); end
      n_chk++; if (s_dn[g] != 2) begin n_fail++; $display("FAIL t6_done[D=%0d]: got %0d want 2", d, s_dn[g]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
